// File: rtl/accel_smoother.sv
// Tilt-sample conditioner: registers raw X/Y, decimates on a prescaler tick,
// averages 2^LOG2_N samples per axis and snaps near-centre averages to CENTER.
module accel_smoother #(
    parameter int SAMPLE_DIV = 50000,
    parameter int LOG2_N     = 3,
    parameter int CENTER     = 256,
    parameter int DEADZONE   = 4
) (
    input  logic       clock,
    input  logic       anti_reset,
    input  logic [8:0] accel_x_raw,
    input  logic [8:0] accel_y_raw,
    input  logic       hold,
    output logic [8:0] accel_x_out,
    output logic [8:0] accel_y_out,
    output logic       out_valid,
    output logic       window_busy
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int AW = 9 + LOG2_N;
    localparam logic signed [10:0] CENTER_S = 11'(CENTER);
    localparam logic signed [10:0] DZ_S     = 11'(DEADZONE);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [AW-1:0]     sum_x, sum_y;
    logic [8:0]        x_in_q, y_in_q;
    logic [8:0]        x_out_q, x_out_d, y_out_q, y_out_d;
    logic              valid_q, valid_d;
    logic              tick;

    function automatic logic [8:0] snap(input logic [8:0] avg);
        logic signed [10:0] diff;
        diff = signed'({2'b00, avg}) - CENTER_S;
        if (diff <= DZ_S && diff >= -DZ_S) return 9'(CENTER);
        return avg;
    endfunction

    assign tick  = (state_q == ACCUM) && (presc_q == PW'(SAMPLE_DIV - 1));
    assign sum_x = acc_x_q + AW'(x_in_q);
    assign sum_y = acc_y_q + AW'(y_in_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) state_q <= ACCUM;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (hold)  state_d = HOLD;
            HOLD:    if (!hold) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        valid_d = 1'b0;
        if (state_q == HOLD || hold) begin
            // Entering or sitting in HOLD drops any partial window, even on a tick.
            presc_d = '0;
            cnt_d   = '0;
            acc_x_d = '0;
            acc_y_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (cnt_q == '1) begin
                    x_out_d = snap(sum_x[AW-1:LOG2_N]);
                    y_out_d = snap(sum_y[AW-1:LOG2_N]);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    acc_x_d = '0;
                    acc_y_d = '0;
                end else begin
                    acc_x_d = sum_x;
                    acc_y_d = sum_y;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            x_in_q  <= '0;
            y_in_q  <= '0;
            x_out_q <= 9'(CENTER);
            y_out_q <= 9'(CENTER);
            valid_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            x_in_q  <= accel_x_raw;
            y_in_q  <= accel_y_raw;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        accel_x_out = x_out_q;
        accel_y_out = y_out_q;
        out_valid   = valid_q;
        window_busy = (cnt_q != '0);
    end

endmodule

// File: tb/tb_accel_smoother.sv
// Self-checking bench for accel_smoother: directed vectors, hand-written corner
// sequences and a randomized run against a queue-based window-average model.
module tb_accel_smoother;

    localparam int SAMPLE_DIV = 4;
    localparam int LOG2_N     = 2;
    localparam int CENTER     = 256;
    localparam int DEADZONE   = 4;
    localparam int N          = 1 << LOG2_N;
    localparam int WIN        = SAMPLE_DIV * N;

    logic       clock = 1'b0;
    logic       anti_reset = 1'b1;
    logic [8:0] accel_x_raw = '0;
    logic [8:0] accel_y_raw = '0;
    logic       hold = 1'b0;
    logic [8:0] accel_x_out, accel_y_out;
    logic       out_valid, window_busy;

    accel_smoother #(
        .SAMPLE_DIV(SAMPLE_DIV), .LOG2_N(LOG2_N), .CENTER(CENTER), .DEADZONE(DEADZONE)
    ) dut (
        .clock(clock), .anti_reset(anti_reset),
        .accel_x_raw(accel_x_raw), .accel_y_raw(accel_y_raw), .hold(hold),
        .accel_x_out(accel_x_out), .accel_y_out(accel_y_out),
        .out_valid(out_valid), .window_busy(window_busy)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_cnt  = 0;

    // Reference model: a list of samples per window, averaged with plain arithmetic.
    int m_reg_x, m_reg_y, m_phase, m_out_x, m_out_y;
    bit m_holding, m_valid;
    int q_x[$];
    int q_y[$];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int snap_model(input int avg);
        if (avg >= CENTER - DEADZONE && avg <= CENTER + DEADZONE) return CENTER;
        return avg;
    endfunction

    function automatic int window_avg(input int q[$]);
        int sum = 0;
        foreach (q[i]) sum += q[i];
        return sum / N;
    endfunction

    task automatic model_reset();
        m_reg_x = 0; m_reg_y = 0; m_phase = 0;
        m_out_x = CENTER; m_out_y = CENTER;
        m_holding = 0; m_valid = 0;
        q_x.delete(); q_y.delete();
    endtask

    task automatic model_edge(input int x, input int y, input bit h);
        m_valid = 0;
        if (m_holding) begin
            if (!h) m_holding = 0;
        end else if (h) begin
            m_holding = 1;
            m_phase = 0;
            q_x.delete(); q_y.delete();
        end else if (m_phase == SAMPLE_DIV - 1) begin
            m_phase = 0;
            q_x.push_back(m_reg_x);
            q_y.push_back(m_reg_y);
            if (q_x.size() == N) begin
                m_out_x = snap_model(window_avg(q_x));
                m_out_y = snap_model(window_avg(q_y));
                m_valid = 1;
                q_x.delete(); q_y.delete();
            end
        end else begin
            m_phase++;
        end
        m_reg_x = x;
        m_reg_y = y;
    endtask

    task automatic step(input int x, input int y, input bit h);
        accel_x_raw = 9'(x);
        accel_y_raw = 9'(y);
        hold = h;
        @(posedge clock);
        #1;
        model_edge(x, y, h);
        edge_cnt++;
        check("model_valid", int'(out_valid), int'(m_valid));
        check("model_x", int'(accel_x_out), m_out_x);
        check("model_y", int'(accel_y_out), m_out_y);
        check("model_busy", int'(window_busy), int'(q_x.size() != 0));
    endtask

    // Pulls reset mid-cycle, checks the asynchronous reset state, then releases
    // just after an edge so the next edge is the first one out of reset.
    task automatic apply_reset(input string tag);
        #2;
        anti_reset = 1'b0;
        #1;
        check({tag, "_rst_x"}, int'(accel_x_out), CENTER);
        check({tag, "_rst_y"}, int'(accel_y_out), CENTER);
        check({tag, "_rst_valid"}, int'(out_valid), 0);
        check({tag, "_rst_busy"}, int'(window_busy), 0);
        model_reset();
        @(posedge clock);
        #1;
        anti_reset = 1'b1;
        edge_cnt = 0;
    endtask

    typedef struct {
        int x;
        int y;
        int ex;
        int ey;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   first_v, second_v, seen, got_x, found;
        int   floor_vals[4];

        vecs[0] = '{300, 100, 300, 100};
        vecs[1] = '{259, 256, 256, 256};
        vecs[2] = '{260, 252, 256, 256};
        vecs[3] = '{261, 251, 261, 251};
        vecs[4] = '{251, 261, 251, 261};
        vecs[5] = '{252, 260, 256, 256};
        vecs[6] = '{511,   0, 511,   0};
        vecs[7] = '{  0, 511,   0, 511};
        vecs[8] = '{ 10, 300,  10, 300};
        floor_vals = '{10, 11, 12, 14};

        model_reset();
        apply_reset("init");

        // First output after 4 ticks (edge 16), then one pulse every window.
        first_v = -1; second_v = -1;
        for (int i = 0; i < 40; i++) begin
            step(300, 100, 0);
            if (out_valid) begin
                if (first_v < 0) first_v = edge_cnt;
                else if (second_v < 0) second_v = edge_cnt;
            end
        end
        check("first_valid_edge", first_v, 16);
        check("second_valid_edge", second_v, 32);
        check("const_x", int'(accel_x_out), 300);
        check("const_y", int'(accel_y_out), 100);

        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < 3 * WIN; c++) step(vecs[v].x, vecs[v].y, 0);
            check($sformatf("vec%0d_x", v), int'(accel_x_out), vecs[v].ex);
            check($sformatf("vec%0d_y", v), int'(accel_y_out), vecs[v].ey);
        end

        // Floor: samples 10,11,12,14 average to 11.
        apply_reset("floor");
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < SAMPLE_DIV; c++) step(floor_vals[k], 256, 0);
        check("floor_valid", int'(out_valid), 1);
        check("floor_x", int'(accel_x_out), 11);
        check("floor_y", int'(accel_y_out), 256);

        // Hold after two samples of a window discards them.
        apply_reset("hold");
        for (int c = 0; c < WIN; c++) step(300, 300, 0);
        check("hold_pre_x", int'(accel_x_out), 300);
        for (int c = 0; c < 2 * SAMPLE_DIV; c++) step(300, 300, 0);
        check("hold_pre_busy", int'(window_busy), 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step(400, 400, 1);
            if (out_valid) seen++;
        end
        check("hold_no_valid", seen, 0);
        check("hold_busy", int'(window_busy), 0);
        check("hold_keep_x", int'(accel_x_out), 300);
        found = 0; got_x = -1;
        for (int c = 0; c < 2 * WIN && found == 0; c++) begin
            step(400, 400, 0);
            if (out_valid) begin
                found = 1;
                got_x = int'(accel_x_out);
            end
        end
        check("hold_release_found", found, 1);
        check("hold_release_x", got_x, 400);

        // Asynchronous reset mid-window with outputs at 300.
        apply_reset("mid");
        for (int c = 0; c < WIN + 6; c++) step(300, 300, 0);
        check("mid_pre_x", int'(accel_x_out), 300);
        check("mid_pre_busy", int'(window_busy), 1);
        apply_reset("midwin");

        // Extremes held for 100 windows.
        for (int c = 0; c < 100 * WIN; c++) step(511, 511, 0);
        check("ext_max_x", int'(accel_x_out), 511);
        check("ext_max_y", int'(accel_y_out), 511);
        for (int c = 0; c < 100 * WIN; c++) step(0, 0, 0);
        check("ext_min_x", int'(accel_x_out), 0);
        check("ext_min_y", int'(accel_y_out), 0);

        // Randomized run: mix of near-centre and full-range samples with hold bursts.
        apply_reset("rand");
        begin
            bit h_r = 0;
            int x_r, y_r;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 99) < 2) h_r = ~h_r;
                if ($urandom_range(0, 1) == 0) begin
                    x_r = CENTER - 8 + int'($urandom_range(0, 16));
                    y_r = CENTER - 8 + int'($urandom_range(0, 16));
                end else begin
                    x_r = int'($urandom_range(0, 511));
                    y_r = int'($urandom_range(0, 511));
                end
                step(x_r, y_r, h_r);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
